theta_arbiter: RTL and testbench
================================

THETA_ARBITER -- requirements
Module: theta_arbiter

Interface
REQ-001 SHALL have parameter THETA_LAT, default 1, meaning the theta read latency in cycles (mult_rom registered read).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req0_valid  input  1  round-datapath operand valid.
REQ-005 SHALL have port req0_ready  output  1  round-datapath operand accepted.
REQ-006 SHALL have port req0_data  input  128  round-datapath operand; byte layout as theta data_in.
REQ-007 SHALL have ports req1_valid/req1_ready/req1_data  input/output/input  1/1/128  key-schedule operand, same meaning as requester 0.
REQ-008 SHALL have port rsp0_valid  output  1  requester-0 result valid.
REQ-009 SHALL have port rsp0_ready  input  1  requester-0 result consumed.
REQ-010 SHALL have port rsp0_data  output  128  requester-0 diffused result.
REQ-011 SHALL have ports rsp1_valid/rsp1_ready/rsp1_data  output/input/output  1/1/128  requester-1 result, same meaning as requester 0.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL share one internal theta instance between two requesters, one operation in flight at a time.
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 In IDLE, the arbiter SHALL assert reqN_ready combinationally only for the selected requester; the other ready SHALL be low.
REQ-016 Selection SHALL pick the only valid requester, or on a tie the requester not recorded in last_grant.
REQ-017 On accept (valid&&ready), SHALL register the operand, owner and last_grant<=owner, clear the wait counter and go to WAIT.
REQ-018 In WAIT, the registered operand SHALL drive theta data_in unchanged, and the counter SHALL increment each cycle.
REQ-019 SHALL sample theta deffused_data into the result register on the cycle the counter equals THETA_LAT, then go to RESP; no other sample is permitted.
REQ-020 Accept at edge k SHALL give rspN_valid high from edge k+THETA_LAT+1 (k+2 for the default).
REQ-021 In RESP, the owner's rspN_valid SHALL be high and rspN_data stable until rspN_ready; on that handshake the FSM SHALL go to IDLE.
REQ-022 The non-owner rsp_valid SHALL be low at all times.
REQ-023 Both reqN_ready SHALL be low in WAIT and RESP; requests arriving then stay pending and are not dropped.
REQ-024 SHALL not accept a new request in the same cycle as a response handshake; minimum spacing is THETA_LAT+3 cycles per operation.
REQ-025 rspN_data SHALL hold the last result after the handshake until the next capture.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, last_grant=1 (requester 0 wins the first tie), result register 0, all ready/valid outputs 0 and busy 0.
REQ-027 rst asserted during WAIT or RESP SHALL abort the operation, with no response ever issued for it.
REQ-028 While rst is high, all ready outputs SHALL stay low.

Structure
REQ-029 A shared Anubis package SHALL hold the state encoding, the requester ID constants (REQ_ROUND=0, REQ_KEY=1) and the THETA_LAT default.
REQ-030 SHALL instantiate exactly one theta sub-module; the wait counter width SHALL be $clog2(THETA_LAT+1).

Verification
REQ-031 The bench SHALL cover: req0 data=128'h...00000001, rsp0_ready=1 -> rsp0_valid at accept+2 with low word 32'h06040201 and the rest 0.
REQ-032 The bench SHALL cover: req1 data=all bytes 8'h5A -> rsp1_data=all bytes 8'h5A, rsp0_valid never high.
REQ-033 The bench SHALL cover: both valid from reset -> req0 served first, then req1; alternating grants over 4 back-to-back pairs.
REQ-034 The bench SHALL cover: rsp0_ready held low 5 cycles -> rsp0_valid and rsp0_data stable, busy=1 and req1_ready=0 throughout.
REQ-035 The bench SHALL cover: rst pulsed one cycle in WAIT -> no rsp_valid, busy=0 next cycle, and a pending req accepted on the following IDLE cycle.
REQ-036 The bench SHALL cover: req0_data changed during WAIT -> result unaffected (equals theta of the accepted value).

Source files
------------

// File: rtl/theta_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : theta_arbiter_pkg
//  Purpose  : Shared Anubis definitions: arbiter state encoding, requester
//             IDs, default theta latency and the theta diffusion function.
//  Revision : 1.0 - initial release
// ============================================================================
package theta_arbiter_pkg;

  localparam int THETA_LAT_DEFAULT = 1;

  localparam logic REQ_ROUND = 1'b0;
  localparam logic REQ_KEY   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  // Theta: each 32-bit word is a row of four bytes (byte 0 in bits 7:0),
  // multiplied by the Hadamard matrix had(01,02,04,06).
  function automatic logic [127:0] theta_f(input logic [127:0] d);
    logic [127:0] r;
    logic [7:0]   a;
    logic [7:0]   m2;
    logic [7:0]   m4;
    logic [7:0]   acc;
    r = '0;
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int i = 0; i < 4; i++) begin
          a  = d[32*w + 8*i +: 8];
          m2 = gf_xtime(a);
          m4 = gf_xtime(m2);
          case (i ^ j)
            0:       acc = acc ^ a;
            1:       acc = acc ^ m2;
            2:       acc = acc ^ m4;
            default: acc = acc ^ m4 ^ m2;
          endcase
        end
        r[32*w + 8*j +: 8] = acc;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/theta_arbiter_theta.sv
`default_nettype none
// ============================================================================
//  Module   : theta_arbiter_theta
//  Purpose  : Anubis theta diffusion with a THETA_LAT-stage registered read.
//  Revision : 1.0 - initial release
// ============================================================================
module theta_arbiter_theta
  import theta_arbiter_pkg::*;
#(
  parameter int THETA_LAT = THETA_LAT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_in,
  output logic [127:0] deffused_data
);

  generate
    if (THETA_LAT == 0) begin : g_comb
      assign deffused_data = theta_f(data_in);
    end else begin : g_pipe
      logic [127:0] pipe_q [THETA_LAT];

      // Result pipeline: stage 0 holds theta of the input, later stages delay it.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < THETA_LAT; s++) pipe_q[s] <= '0;
        end else begin
          pipe_q[0] <= theta_f(data_in);
          for (int s = 1; s < THETA_LAT; s++) pipe_q[s] <= pipe_q[s-1];
        end
      end

      assign deffused_data = pipe_q[THETA_LAT-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/theta_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : theta_arbiter
//  Purpose  : Shares one theta unit between the round datapath (req0) and
//             the key schedule (req1), one operation in flight at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module theta_arbiter
  import theta_arbiter_pkg::*;
#(
  parameter int THETA_LAT = THETA_LAT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [127:0] rsp0_data,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp1_data,
  output logic         busy
);

  // A zero-latency theta still needs a one-bit counter.
  localparam int CW = (THETA_LAT > 0) ? $clog2(THETA_LAT + 1) : 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   operand_q, operand_d;
  logic [127:0]   result_q, result_d;
  logic           owner_q, owner_d;
  logic           last_grant_q, last_grant_d;
  logic           sel;
  logic           any_valid;
  logic [127:0]   theta_out;

  theta_arbiter_theta #(
    .THETA_LAT(THETA_LAT)
  ) u_theta (
    .clk           (clk),
    .rst           (rst),
    .data_in       (operand_q),
    .deffused_data (theta_out)
  );

  // Grant selection: a lone requester wins; a tie goes to whoever was not granted last.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && !req1_valid)      sel = REQ_ROUND;
    else if (req1_valid && !req0_valid) sel = REQ_KEY;
    else                                sel = ~last_grant_q;
  end

  // Next-state, capture and handshake logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    operand_d    = operand_q;
    result_d     = result_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rst && any_valid) begin
          req0_ready   = (sel == REQ_ROUND);
          req1_ready   = (sel == REQ_KEY);
          operand_d    = (sel == REQ_KEY) ? req1_data : req0_data;
          owner_d      = sel;
          last_grant_d = sel;
          cnt_d        = '0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The operand register stays put so theta sees a stable input.
        if (cnt_q == CW'(THETA_LAT)) begin
          result_d = theta_out;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        if ((owner_q == REQ_ROUND && rsp0_ready) || (owner_q == REQ_KEY && rsp1_ready)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      operand_q    <= '0;
      result_q     <= '0;
      owner_q      <= REQ_ROUND;
      last_grant_q <= REQ_KEY;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      operand_q    <= operand_d;
      result_q     <= result_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp0_valid = !rst && (state_q == ST_RESP) && (owner_q == REQ_ROUND);
  assign rsp1_valid = !rst && (state_q == ST_RESP) && (owner_q == REQ_KEY);
  assign rsp0_data  = result_q;
  assign rsp1_data  = result_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_theta_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_theta_arbiter
//  Purpose  : Directed, table-driven bench for theta_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_theta_arbiter;

  localparam int LAT = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_data, req1_data;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [127:0] rsp0_data, rsp1_data;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit           r;
    logic [127:0] d;
    logic [127:0] e;
  } vec_t;

  vec_t v[8];

  theta_arbiter #(.THETA_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("ready_in_rst", {req1_ready, req0_ready}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rspv", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("rst_data", rsp0_data, 128'h0);
  endtask

  // One complete operation on requester r; the request data is corrupted
  // right after acceptance to show the result depends only on the accepted operand.
  task automatic do_op(input bit r, input logic [127:0] d, input logic [127:0] e);
    int  k, t;
    bit  other_hi;
    @(negedge clk);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (r) begin req1_valid = 1'b1; req1_data = d; end
    else   begin req0_valid = 1'b1; req0_data = d; end
    t = 0;
    while (!(r ? req1_ready : req0_ready) && t < 20) begin @(negedge clk); t++; end
    chk("accept_timeout", t < 20, 1'b1);
    k = cyc + 1;
    @(negedge clk);
    if (r) begin req1_valid = 1'b0; req1_data = ~d; end
    else   begin req0_valid = 1'b0; req0_data = ~d; end
    t = 0;
    other_hi = 1'b0;
    while (!(r ? rsp1_valid : rsp0_valid) && t < 20) begin
      if (r ? rsp0_valid : rsp1_valid) other_hi = 1'b1;
      @(negedge clk);
      t++;
    end
    chk("rsp_latency", cyc - k, LAT + 1);
    chk("rsp_data", r ? rsp1_data : rsp0_data, e);
    chk("nonowner_valid", {other_hi, (r ? rsp0_valid : rsp1_valid)}, 2'b00);
    @(negedge clk);
    chk("idle_after_hs", busy, 1'b0);
    chk("data_held", r ? rsp1_data : rsp0_data, e);
  endtask

  initial begin
    int t, prev;
    logic [127:0] held;

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0;    req1_data = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    v[0] = '{1'b0, 128'h1,                     128'h06040201};
    v[1] = '{1'b1, {16{8'h5A}},                {16{8'h5A}}};
    v[2] = '{1'b0, 128'h100,                   128'h04060102};
    v[3] = '{1'b1, 128'h1_0000_0000,           128'h06040201_00000000};
    v[4] = '{1'b0, 128'h02,                    128'h0C080402};
    v[5] = '{1'b1, 128'h80,                    128'h273A1D80};
    v[6] = '{1'b0, 128'h0,                     128'h0};
    v[7] = '{1'b1, 128'h01000000 << 96,        128'h01020406 << 96};

    do_reset();

    for (int i = 0; i < 8; i++) do_op(v[i].r, v[i].d, v[i].e);

    // Both requesters valid from reset: req0 first, then strict alternation.
    do_reset();
    req0_data = 128'h1;
    req1_data = {16{8'h5A}};
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    prev = 0;
    for (int n = 0; n < 8; n++) begin
      t = 0;
      while (!(req0_ready || req1_ready) && t < 20) begin @(negedge clk); t++; end
      chk("alt_grant", {req1_ready, req0_ready}, (n % 2) ? 2'b10 : 2'b01);
      if (n > 0) chk("alt_spacing", cyc + 1 - prev, LAT + 3);
      prev = cyc + 1;
      @(negedge clk);
      t = 0;
      while (!(rsp0_valid || rsp1_valid) && t < 20) begin @(negedge clk); t++; end
      chk("alt_data", (n % 2) ? rsp1_data : rsp0_data,
          (n % 2) ? {16{8'h5A}} : 128'h06040201);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Response back-pressure with req1 pending.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 128'h02;
    t = 0;
    while (!req0_ready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 128'h80;
    t = 0;
    while (!rsp0_valid && t < 20) begin @(negedge clk); t++; end
    held = rsp0_data;
    for (int i = 0; i < 5; i++) begin
      chk("hold_state", {rsp0_valid, busy, req1_ready, rsp1_valid}, 4'b1100);
      chk("hold_data", rsp0_data, 128'h0C080402);
      chk("hold_stable", rsp0_data, held);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("pending_ready", {req1_ready, req0_ready}, 2'b10);
    @(negedge clk);
    req1_valid = 1'b0;
    t = 0;
    while (!rsp1_valid && t < 20) begin @(negedge clk); t++; end
    chk("pending_data", rsp1_data, 128'h273A1D80);
    @(negedge clk);

    // Reset pulse during WAIT aborts req0; pending req1 is served afterwards.
    req0_valid = 1'b1;
    req0_data  = 128'h1;
    t = 0;
    while (!req0_ready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_data  = {16{8'h5A}};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_rspv", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("abort_ready", {req1_ready, req0_ready}, 2'b10);
    @(negedge clk);
    req1_valid = 1'b0;
    t = 0;
    prev = 0;
    while (!rsp1_valid && t < 20) begin
      if (rsp0_valid) prev = 1;
      @(negedge clk);
      t++;
    end
    chk("abort_no_rsp0", prev, 0);
    chk("abort_rsp1", rsp1_data, {16{8'h5A}});
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
